// File: rtl/serial_rx_param_if.sv
// Receiver port bundle: serial line in, received word and status strobes out.
interface serial_rx_param_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  rxd;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_on_line;
  logic                  parity_err;
  logic                  frame_err;
  logic                  busy;

  // Receiver side: samples the line, presents the word and strobes.
  modport master (
    input  rxd,
    output word, word_on_line, parity_err, frame_err, busy
  );

  // Consumer side: drives the line, captures the word on its strobe.
  modport slave (
    output rxd,
    input  word, word_on_line, parity_err, frame_err, busy
  );
endinterface

// File: rtl/serial_rx_param.sv
// Parametrised asynchronous serial receiver: rxd synchroniser, mid-bit
// oversampled framing with false-start rejection, optional parity and
// stop-bit checking. Each accepted word is announced by a one-cycle strobe.
module serial_rx_param #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned MSB_FIRST    = 1,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  serial_rx_param_if.master rx
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam int unsigned   IW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic                   perr_q, perr_d;      // parity verdict of the frame in flight
  logic                   wol_q, wol_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;

  assign rxs = sync_q[SYNC_STAGES-1];

  // rxd synchroniser: shift the raw pin through SYNC_STAGES flops.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx.rxd};
  end

  // Framing FSM: next state, counters, shift register and output strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    word_d     = word_q;
    wol_d      = 1'b0;
    perr_out_d = 1'b0;
    ferr_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      // Half a bit into the start bit: confirm it is still low, which also
      // places every later sample at a bit centre.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + IW'(1);
          // Shift-then-insert keeps DATA_WIDTH==1 legal (no empty slices).
          if (MSB_FIRST != 0) begin
            shift_d    = shift_q << 1;
            shift_d[0] = rxs;
          end else begin
            shift_d                 = shift_q >> 1;
            shift_d[DATA_WIDTH-1]   = rxs;
          end
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 2) ? ~(^shift_q ^ rxs) : (^shift_q ^ rxs);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            word_d     = shift_q;
            wol_d      = 1'b1;
            perr_out_d = (PARITY != 0) ? perr_q : 1'b0;
            state_d    = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Held-low line after a framing error: wait for idle before rearming.
      S_BREAK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Register synchroniser, FSM state, datapath and all outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      word_q     <= '0;
      wol_q      <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      word_q     <= word_d;
      wol_q      <= wol_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx.word         = word_q;
  assign rx.word_on_line = wol_q;
  assign rx.parity_err   = perr_out_q;
  assign rx.frame_err    = ferr_q;
  assign rx.busy         = busy_q;

endmodule

// File: tb/tb_serial_rx_param.sv
// Bench for serial_rx_param: four receivers with different generics, a line
// driver, an event recorder and a behavioural frame model.
module tb_serial_rx_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rxd_v = 4'b1111;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          viol_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          s;
    logic        fe;
    logic [15:0] w;
    logic        pe;
    int unsigned c;
  } ev_t;

  typedef struct {
    logic [15:0] w;
    logic        pe;
    int unsigned c;
  } exp_t;

  ev_t capq[$];

  serial_rx_param_if #(.DATA_WIDTH(8)) if0 ();
  serial_rx_param_if #(.DATA_WIDTH(8)) if1 ();
  serial_rx_param_if #(.DATA_WIDTH(8)) if2 ();
  serial_rx_param_if #(.DATA_WIDTH(5)) if3 ();

  assign if0.rxd = rxd_v[0];
  assign if1.rxd = rxd_v[1];
  assign if2.rxd = rxd_v[2];
  assign if3.rxd = rxd_v[3];

  serial_rx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1), .PARITY(0), .SYNC_STAGES(2))
    u_dut0 (.clk(clk), .rst(rst), .rx(if0));
  serial_rx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(0), .PARITY(0), .SYNC_STAGES(2))
    u_dut1 (.clk(clk), .rst(rst), .rx(if1));
  serial_rx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1), .PARITY(1), .SYNC_STAGES(2))
    u_dut2 (.clk(clk), .rst(rst), .rx(if2));
  serial_rx_param #(.DATA_WIDTH(5), .CLKS_PER_BIT(6), .MSB_FIRST(0), .PARITY(2), .SYNC_STAGES(3))
    u_dut3 (.clk(clk), .rst(rst), .rx(if3));

  logic [15:0] obs_word [4];
  logic [3:0]  obs_wol, obs_perr, obs_ferr, obs_busy;

  assign obs_word[0] = 16'(if0.word);
  assign obs_word[1] = 16'(if1.word);
  assign obs_word[2] = 16'(if2.word);
  assign obs_word[3] = 16'(if3.word);
  assign obs_wol  = {if3.word_on_line, if2.word_on_line, if1.word_on_line, if0.word_on_line};
  assign obs_perr = {if3.parity_err, if2.parity_err, if1.parity_err, if0.parity_err};
  assign obs_ferr = {if3.frame_err, if2.frame_err, if1.frame_err, if0.frame_err};
  assign obs_busy = {if3.busy, if2.busy, if1.busy, if0.busy};

  // Generics of each instance, as the bench sees them.
  function automatic int p_dw(int s);   return (s == 3) ? 5 : 8; endfunction
  function automatic int p_cpb(int s);  return (s == 3) ? 6 : 4; endfunction
  function automatic int p_msb(int s);  return (s == 0 || s == 2) ? 1 : 0; endfunction
  function automatic int p_par(int s);  return (s == 2) ? 1 : ((s == 3) ? 2 : 0); endfunction
  function automatic int p_sync(int s); return (s == 3) ? 3 : 2; endfunction

  // Cycles from driving the start bit to the strobe: synchroniser delay
  // plus half a bit, the remaining frame bits and one output register.
  function automatic int unsigned exp_lat(int s);
    return p_sync(s) + p_cpb(s) / 2 + (p_dw(s) + (p_par(s) != 0 ? 1 : 0) + 1) * p_cpb(s) + 1;
  endfunction

  // bits[i] is the i-th data bit on the line.
  function automatic logic [15:0] model_word(int s, logic [15:0] bits);
    logic [15:0] w = '0;
    for (int i = 0; i < p_dw(s); i++) begin
      int pos = (p_msb(s) != 0) ? (p_dw(s) - 1 - i) : i;
      if (bits[i]) w = w | (16'd1 << pos);
    end
    return w;
  endfunction

  function automatic logic model_perr(int s, logic [15:0] bits, logic pbit);
    int ones = $countones(bits) + int'(pbit);
    if (p_par(s) == 1) return (ones % 2) != 0;
    if (p_par(s) == 2) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  // Record every strobe and flag illegal strobe combinations.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (obs_wol[i] || obs_ferr[i])
        capq.push_back('{s: i, fe: obs_ferr[i], w: obs_word[i], pe: obs_perr[i], c: cyc});
      if ((obs_ferr[i] && obs_wol[i]) || (obs_perr[i] && !obs_wol[i]))
        viol_cnt++;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int s, input logic v, input int n);
    rxd_v[s] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int s, input logic [15:0] bits, input logic pbit,
                            input logic stopb, output int unsigned t0);
    t0 = cyc;
    drive(s, 1'b0, p_cpb(s));
    for (int i = 0; i < p_dw(s); i++) drive(s, bits[i], p_cpb(s));
    if (p_par(s) != 0) drive(s, pbit, p_cpb(s));
    drive(s, stopb, p_cpb(s));
    rxd_v[s] = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (obs_word[s] !== 16'h0 || obs_wol[s] !== 1'b0 || obs_perr[s] !== 1'b0 ||
          obs_ferr[s] !== 1'b0 || obs_busy[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got word=%h wol=%b pe=%b fe=%b busy=%b, expected all 0",
                 s, obs_word[s], obs_wol[s], obs_perr[s], obs_ferr[s], obs_busy[s]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (obs_busy !== 4'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b, expected 0000", obs_busy);
    end
  endtask

  task automatic test_msb_first();
    int base = capq.size();
    int unsigned t0;
    send_frame(0, 16'h00A5, 1'b0, 1'b1, t0);
    repeat (10) @(negedge clk);
    checks++;
    if (capq.size() - base != 1) begin
      errors++;
      $display("FAIL msb_first_count: got %0d events, expected 1", capq.size() - base);
    end else begin
      checks++;
      if (capq[base].w !== 16'h00A5 || capq[base].fe !== 1'b0 || capq[base].pe !== 1'b0) begin
        errors++;
        $display("FAIL msb_first_word: got w=%h fe=%b pe=%b, expected w=00a5 fe=0 pe=0",
                 capq[base].w, capq[base].fe, capq[base].pe);
      end
      checks++;
      if (capq[base].c !== t0 + 2 + 39) begin
        errors++;
        $display("FAIL msb_first_latency: got %0d, expected %0d", capq[base].c - t0, 41);
      end
    end
    checks++;
    if (obs_word[0] !== 16'h00A5 || obs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL msb_first_hold: got word=%h busy=%b, expected 00a5 0", obs_word[0], obs_busy[0]);
    end
  endtask

  task automatic test_lsb_first();
    int base = capq.size();
    int unsigned t0, t1;
    send_frame(1, 16'h00A5, 1'b0, 1'b1, t0);   // line 1,0,1,0,0,1,0,1
    repeat (3) @(negedge clk);
    send_frame(1, 16'h0003, 1'b0, 1'b1, t1);   // line 1,1,0,0,0,0,0,0
    repeat (10) @(negedge clk);
    checks++;
    if (capq.size() - base != 2) begin
      errors++;
      $display("FAIL lsb_first_count: got %0d events, expected 2", capq.size() - base);
    end else begin
      checks++;
      if (capq[base].w !== 16'h00A5 || capq[base].c !== t0 + 41) begin
        errors++;
        $display("FAIL lsb_first_a5: got w=%h lat=%0d, expected w=00a5 lat=41",
                 capq[base].w, capq[base].c - t0);
      end
      checks++;
      if (capq[base+1].w !== 16'h0003 || capq[base+1].fe !== 1'b0) begin
        errors++;
        $display("FAIL lsb_first_03: got w=%h fe=%b, expected w=0003 fe=0",
                 capq[base+1].w, capq[base+1].fe);
      end
    end
  endtask

  task automatic test_even_parity();
    int base = capq.size();
    int unsigned t0, t1;
    send_frame(2, 16'h0081, 1'b1, 1'b1, t0);
    repeat (3) @(negedge clk);
    send_frame(2, 16'h0081, 1'b0, 1'b1, t1);
    repeat (10) @(negedge clk);
    checks++;
    if (capq.size() - base != 2) begin
      errors++;
      $display("FAIL even_parity_count: got %0d events, expected 2", capq.size() - base);
    end else begin
      checks++;
      if (capq[base].w !== 16'h0081 || capq[base].pe !== 1'b1 || capq[base].c !== t0 + 45) begin
        errors++;
        $display("FAIL even_parity_bad: got w=%h pe=%b lat=%0d, expected w=0081 pe=1 lat=45",
                 capq[base].w, capq[base].pe, capq[base].c - t0);
      end
      checks++;
      if (capq[base+1].w !== 16'h0081 || capq[base+1].pe !== 1'b0) begin
        errors++;
        $display("FAIL even_parity_good: got w=%h pe=%b, expected w=0081 pe=0",
                 capq[base+1].w, capq[base+1].pe);
      end
    end
  endtask

  task automatic test_frame_error();
    int base = capq.size();
    int unsigned t0, t1;
    logic busy_held;
    send_frame(0, 16'h00A5, 1'b0, 1'b1, t0);
    repeat (4) @(negedge clk);
    send_frame(0, 16'($urandom_range(0, 255)), 1'b0, 1'b0, t1);
    drive(0, 1'b0, 3 * 4);
    busy_held = obs_busy[0];
    checks++;
    if (busy_held !== 1'b1 || obs_word[0] !== 16'h00A5) begin
      errors++;
      $display("FAIL frame_error_break: got busy=%b word=%h, expected busy=1 word=00a5",
               busy_held, obs_word[0]);
    end
    rxd_v[0] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (obs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL frame_error_release: got busy=%b, expected 0", obs_busy[0]);
    end
    repeat (16) @(negedge clk);
    checks++;
    if (capq.size() - base != 2) begin
      errors++;
      $display("FAIL frame_error_count: got %0d events, expected 2", capq.size() - base);
    end else begin
      checks++;
      if (capq[base+1].fe !== 1'b1 || capq[base+1].c !== t1 + 41 || capq[base+1].w !== 16'h00A5) begin
        errors++;
        $display("FAIL frame_error_pulse: got fe=%b lat=%0d word=%h, expected fe=1 lat=41 word=00a5",
                 capq[base+1].fe, capq[base+1].c - t1, capq[base+1].w);
      end
    end
  endtask

  task automatic test_glitch(input int s, input int width);
    int base = capq.size();
    logic [15:0] w0 = obs_word[s];
    logic saw_busy = 1'b0;
    drive(s, 1'b0, width);
    rxd_v[s] = 1'b1;
    repeat (p_sync(s) + p_cpb(s) + 4) begin
      @(negedge clk);
      if (obs_busy[s] === 1'b1) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b1 || obs_busy[s] !== 1'b0 || capq.size() != base || obs_word[s] !== w0) begin
      errors++;
      $display("FAIL glitch[%0d]: got saw_busy=%b busy=%b events=%0d word=%h, expected 1 0 0 %h",
               s, saw_busy, obs_busy[s], capq.size() - base, obs_word[s], w0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base = capq.size();
    int unsigned t0;
    logic [15:0] bits = 16'h003C;
    drive(0, 1'b0, 4);
    for (int i = 0; i < 4; i++) drive(0, bits[i], 4);
    drive(0, bits[4], 2);
    rst = 1'b0;
    rxd_v[0] = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (obs_word[s] !== 16'h0 || obs_wol[s] !== 1'b0 || obs_perr[s] !== 1'b0 ||
          obs_ferr[s] !== 1'b0 || obs_busy[s] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_state[%0d]: got word=%h wol=%b pe=%b fe=%b busy=%b, expected all 0",
                 s, obs_word[s], obs_wol[s], obs_perr[s], obs_ferr[s], obs_busy[s]);
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (capq.size() != base || obs_busy !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_abort: got events=%0d busy=%b, expected 0 0000",
               capq.size() - base, obs_busy);
    end
    send_frame(0, bits, 1'b0, 1'b1, t0);
    repeat (10) @(negedge clk);
    checks++;
    if (capq.size() - base != 1) begin
      errors++;
      $display("FAIL mid_reset_recover_count: got %0d events, expected 1", capq.size() - base);
    end else begin
      checks++;
      if (capq[base].w !== 16'h003C || capq[base].fe !== 1'b0 || capq[base].pe !== 1'b0 ||
          capq[base].c !== t0 + 41) begin
        errors++;
        $display("FAIL mid_reset_recover: got w=%h fe=%b pe=%b lat=%0d, expected 003c 0 0 41",
                 capq[base].w, capq[base].fe, capq[base].pe, capq[base].c - t0);
      end
    end
  endtask

  // Random frames on one instance, optionally with no idle gap between them.
  task automatic test_frames(input int s, input int n, input logic b2b);
    exp_t expq[$];
    int base = capq.size();
    int got;
    logic [15:0] mask = 16'((32'd1 << p_dw(s)) - 1);
    for (int f = 0; f < n; f++) begin
      logic [15:0] bits = 16'($urandom) & mask;
      logic pbit = 1'($urandom_range(0, 1));
      int unsigned t0;
      send_frame(s, bits, pbit, 1'b1, t0);
      expq.push_back('{w: model_word(s, bits), pe: model_perr(s, bits, pbit), c: t0 + exp_lat(s)});
      if (!b2b) repeat ($urandom_range(1, 2 * p_cpb(s))) @(negedge clk);
    end
    repeat (p_cpb(s) + p_sync(s) + 4) @(negedge clk);
    got = capq.size() - base;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL frames_count[%0d b2b=%0b]: got %0d strobes, expected %0d", s, b2b, got, n);
    end
    for (int i = 0; i < n && i < got; i++) begin
      ev_t e = capq[base+i];
      checks++;
      if (e.s != s || e.fe !== 1'b0 || e.w !== expq[i].w || e.pe !== expq[i].pe || e.c !== expq[i].c) begin
        errors++;
        $display("FAIL frame[%0d b2b=%0b #%0d]: got s=%0d fe=%b w=%h pe=%b cyc=%0d, expected s=%0d fe=0 w=%h pe=%b cyc=%0d",
                 s, b2b, i, e.s, e.fe, e.w, e.pe, e.c, s, expq[i].w, expq[i].pe, expq[i].c);
      end
    end
  endtask

  task automatic test_strobe_exclusive();
    checks++;
    if (viol_cnt != 0) begin
      errors++;
      $display("FAIL strobe_exclusive: got %0d illegal strobe cycles, expected 0", viol_cnt);
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_even_parity();
    test_frame_error();
    test_glitch(0, 1);
    test_glitch(3, 2);
    test_reset_mid_frame();
    for (int s = 0; s < 4; s++) begin
      test_frames(s, 6, 1'b0);
      test_frames(s, 5, 1'b1);
    end
    test_strobe_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_param.md
Name: serial_rx_param

Overview:
Parametrised asynchronous serial receiver, next generation of the team's 8-bit line receiver. Adds width/bit-order/parity generics, an input synchroniser, oversampled mid-bit sampling with false-start rejection, and stop/parity error reporting. Sits between the external rxd pin and the byte-consuming logic. Presents each received word with a one-cycle strobe.

Parameters:
DATA_WIDTH, 8, data bits per frame (1..16)
CLKS_PER_BIT, 16, clk cycles per bit period (even, >=4)
MSB_FIRST, 1, 1 = first data bit lands in word[DATA_WIDTH-1]; 0 = LSB first
PARITY, 0, 0 none, 1 even, 2 odd
SYNC_STAGES, 2, flops in rxd synchroniser (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
rxd  input  1  serial line, idle high, asynchronous to clk
word  output  DATA_WIDTH  last accepted word, held until next accept
word_on_line  output  1  one-cycle strobe: word updated this cycle
parity_err  output  1  one-cycle strobe, coincident with word_on_line, parity mismatch
frame_err  output  1  one-cycle strobe: stop bit sampled low
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, asynchronous): synchroniser flops = 1, state = IDLE, counters = 0, shift reg = 0, word = 0, all strobes = 0, busy = 0. Reset mid-frame aborts frame, no strobe.
- rxd passes SYNC_STAGES flops; all decisions use synchronised value rxs.
- Bit counter cnt counts 0..CLKS_PER_BIT-1; bit index idx counts data bits.
- IDLE: rxs==0 -> START, cnt=0.
- START: cnt increments; at cnt==CLKS_PER_BIT/2-1 sample rxs: 1 -> IDLE (glitch rejected, no strobe); 0 -> DATA, cnt=0, idx=0. Aligns later samples to bit centres.
- DATA: at cnt==CLKS_PER_BIT-1 sample rxs into shift reg (MSB_FIRST: shift left, insert at bit 0; else shift right, insert at bit DATA_WIDTH-1), cnt=0, idx++; after DATA_WIDTH-th sample -> PARITY if PARITY!=0 else STOP.
- PARITY: at cnt==CLKS_PER_BIT-1 sample parity bit; perr = (XOR of data ^ bit) != 0 for even, == 0 for odd -> STOP.
- STOP: at cnt==CLKS_PER_BIT-1 sample rxs:
  1 -> next cycle: word <= shift reg, word_on_line=1, parity_err=perr; state -> IDLE.
  0 -> next cycle: frame_err=1, word unchanged, word_on_line=0; state -> BREAK.
- BREAK: wait for rxs==1, then -> IDLE (no re-trigger on held-low line/break).
- Latency: from first cycle rxs==0 in IDLE to strobe = CLKS_PER_BIT/2 + (DATA_WIDTH + (PARITY!=0) + 1)*CLKS_PER_BIT + 1 cycles.
- Back-to-back frames: new start bit accepted the cycle after return to IDLE; a start edge falling during the strobe cycle is detected next cycle (sub-half-bit skew tolerated).
- Strobes are never asserted simultaneously except word_on_line with parity_err.
- No backpressure: consumer must capture word on strobe; word holds until next good frame.

Test Plan:
1. DATA_WIDTH=8, CLKS_PER_BIT=4, MSB_FIRST=1, PARITY=0; send 0xA5 idle-high framed -> word=0xA5, word_on_line high exactly 1 cycle, 39 cycles after rxs first low; frame_err=0.
2. MSB_FIRST=0, same line bit sequence 1,0,1,0,0,1,0,1 -> word=0xA5 reversed = 0xA5 then send 1,1,0,0,0,0,0,0 -> word=0x03.
3. PARITY=1 (even), send 0x81 with parity bit 1 -> word=0x81, word_on_line=1, parity_err=1; with parity bit 0 -> parity_err=0.
4. Stop bit driven low, line held low 3 bit times -> frame_err 1-cycle pulse, word keeps previous 0xA5, busy stays high until line high, no spurious start.
5. rxd low pulse of 1 cycle (shorter than CLKS_PER_BIT/2) while idle -> returns to IDLE, no strobes, word unchanged.
6. rst driven low mid-data-bit 4, released, then clean frame 0x3C -> all outputs 0 during reset, next frame gives word=0x3C with no error.
